// File: rtl/init_write_seq.sv
// Initial-value loader: streams a linear table of register values to a
// downstream stage over a valid/ready write channel, then raises done.
module init_write_seq #(
   parameter int                NUM_REGS   = 4,
   parameter int                ADDR_W     = 2,
   parameter int                DATA_W     = 32,
   parameter logic [DATA_W-1:0] BASE_VAL   = 22,
   parameter logic [DATA_W-1:0] STEP_VAL  = 11,
   parameter int                AUTO_START = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic              start_ovr,
   output logic [31:0]       cyc
);

   if (NUM_REGS < 1 || NUM_REGS > (1 << ADDR_W)) begin : g_bad_cfg
      $error("init_write_seq: NUM_REGS must be in 1..2**ADDR_W");
   end

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q;
   logic [DATA_W-1:0] data_q;
   logic              started_q;
   logic              go;
   logic              load;

   // Auto-start fires only on the first posedge after reset; a coincident
   // start merges into the same single launch.
   assign go   = start || ((AUTO_START != 0) && !started_q);
   assign load = (state_q != WRITE) && (state_d == WRITE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (go) state_d = WRITE;
         WRITE:   if (wr_ready && idx_q == LAST) state_d = DONE;
         DONE:    if (start) state_d = WRITE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_valid = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         WRITE:   begin wr_valid = 1'b1; busy = 1'b1; end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Entry value is accumulated rather than multiplied; the last entry is
   // left in place so addr/data hold it while DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q     <= '0;
         data_q    <= '0;
         started_q <= 1'b0;
         start_ovr <= 1'b0;
         cyc       <= 32'd0;
      end else begin
         started_q <= 1'b1;
         cyc       <= cyc + 32'd1;
         if (start && state_q == WRITE) start_ovr <= 1'b1;
         if (load) begin
            idx_q  <= '0;
            data_q <= BASE_VAL;
         end else if (state_q == WRITE && wr_ready && idx_q != LAST) begin
            idx_q  <= idx_q + ADDR_W'(1);
            data_q <= data_q + STEP_VAL;
         end
      end
   end

   assign wr_addr = idx_q;
   assign wr_data = data_q;

endmodule

// File: tb/tb_init_write_seq.sv
// Randomized scoreboard bench for init_write_seq: an auto-start instance with
// default table and a manual-start instance with a wrapping table.
module tb_init_write_seq;
   typedef struct {
      logic [1:0]  addr;
      logic [31:0] data;
   } wr_t;

   localparam logic [31:0] A_BASE = 32'd22;
   localparam logic [31:0] A_STEP = 32'd11;
   localparam logic [31:0] B_BASE = 32'hFFFF_FFF0;
   localparam logic [31:0] B_STEP = 32'd8;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start = 1'b0, rdy = 1'b1;
   logic startb = 1'b0, rdyb = 1'b1;
   logic va, busya, donea, ovra, vb, busyb, doneb, ovrb;
   logic [1:0]  aa, ab;
   logic [31:0] da, db, cyca, cycb;

   int total = 0, bad = 0;
   int nxa = 0;
   logic [31:0] mcyc;
   logic [31:0] last_xfer_cyc = 0;
   wr_t qa[$], qb[$];

   always #5 clk = ~clk;

   init_write_seq dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .wr_valid(va), .wr_ready(rdy),
      .wr_addr(aa), .wr_data(da), .busy(busya), .done(donea),
      .start_ovr(ovra), .cyc(cyca));

   init_write_seq #(.AUTO_START(0), .BASE_VAL(B_BASE), .STEP_VAL(B_STEP)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(startb), .wr_valid(vb), .wr_ready(rdyb),
      .wr_addr(ab), .wr_data(db), .busy(busyb), .done(doneb),
      .start_ovr(ovrb), .cyc(cycb));

   // Reference count of posedges since reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mcyc <= 32'd0;
      else        mcyc <= mcyc + 32'd1;
   end

   function automatic logic [31:0] entry(input logic [31:0] base, step, input int i);
      return base + step * i;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic push_seq(input bit b);
      wr_t w;
      for (int i = 0; i < 4; i++) begin
         w.addr = 2'(i);
         w.data = b ? entry(B_BASE, B_STEP, i) : entry(A_BASE, A_STEP, i);
         if (b) qb.push_back(w); else qa.push_back(w);
      end
   endtask

   // Monitor A: transfer predicted at negedge completes at the next posedge
   initial begin
      bit stall = 0;
      logic [1:0] s_addr;
      logic [31:0] s_data;
      wr_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) stall = 0;
         else begin
            chk("cyc", cyca, mcyc);
            if (stall) begin
               chk("stall_valid", va, 1);
               chk("stall_addr", aa, s_addr);
               chk("stall_data", da, s_data);
            end
            if (va && rdy) begin
               total++;
               if (qa.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_wr_a act=%0h/%0h exp=none", aa, da);
               end else begin
                  e = qa.pop_front();
                  if (aa !== e.addr || da !== e.data) begin
                     bad++;
                     $display("FAIL wr_a act=%0h/%0h exp=%0h/%0h", aa, da, e.addr, e.data);
                  end
               end
               nxa++;
               last_xfer_cyc = mcyc + 32'd1;
            end
            stall = va && !rdy;
            s_addr = aa;
            s_data = da;
         end
      end
   end

   // Monitor B
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (rst_n && vb && rdyb) begin
            total++;
            if (qb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_wr_b act=%0h/%0h exp=none", ab, db);
            end else begin
               e = qb.pop_front();
               if (ab !== e.addr || db !== e.data) begin
                  bad++;
                  $display("FAIL wr_b act=%0h/%0h exp=%0h/%0h", ab, db, e.addr, e.data);
               end
            end
         end
      end
   end

   task automatic pulse(input bit b);
      @(posedge clk); #1;
      if (b) startb = 1; else start = 1;
      @(posedge clk); #1;
      startb = 0; start = 0;
   endtask

   task automatic run_until_done(input bit rnd);
      bit ok = 0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk); #1;
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (donea) begin ok = 1; break; end
      end
      chk("done_timeout", ok, 1);
      chk("sb_empty_a", qa.size(), 0);
      chk("done_latency", cyca, last_xfer_cyc);
   endtask

   task automatic chk_zero_a();
      chk("rst_valid", va, 0);  chk("rst_addr", aa, 0);  chk("rst_data", da, 0);
      chk("rst_busy", busya, 0); chk("rst_done", donea, 0);
      chk("rst_ovr", ovra, 0);  chk("rst_cyc", cyca, 0);
   endtask

   initial begin
      int base;
      bit ok;
      // 1: reset, auto-start, ready high
      #1 rst_n = 0;
      #2 chk_zero_a();
      push_seq(0);
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      run_until_done(0);
      chk("done_cyc", cyca, 5);
      @(posedge clk); #1;
      chk("done_valid", va, 0);
      chk("done_busy", busya, 0);
      chk("done_hold", donea, 1);
      chk("hold_addr", aa, 3);
      chk("hold_data", da, entry(A_BASE, A_STEP, 3));
      chk("b_idle_valid", vb, 0);
      chk("b_idle_busy", busyb, 0);

      // 2: restart from DONE with random backpressure
      push_seq(0);
      pulse(0);
      chk("restart_done_low", donea, 0);
      chk("restart_busy", busya, 1);
      run_until_done(1);

      // 3: start while busy sets sticky overrun
      rdy = 1;
      push_seq(0);
      pulse(0);
      chk("ovr_before", ovra, 0);
      pulse(0);
      chk("ovr_set", ovra, 1);
      run_until_done(0);
      repeat (3) @(posedge clk);
      #1 chk("ovr_sticky", ovra, 1);

      // 4: async reset after the 2nd transfer
      push_seq(0);
      pulse(0);
      base = nxa;
      ok = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (nxa >= base + 2) begin ok = 1; break; end
      end
      chk("xfer2_timeout", ok, 1);
      @(posedge clk); #1 rst_n = 0;
      #1 chk_zero_a();
      qa.delete();
      push_seq(0);
      @(negedge clk);
      rst_n = 1;
      start = 1;  // coincides with auto-start: one launch, no overrun
      @(posedge clk); #1 start = 0;
      run_until_done(0);
      chk("rerun_done_cyc", cyca, 5);
      chk("rerun_ovr", ovra, 0);

      // 5: manual-start instance with wrapping table
      chk("b_still_idle", vb, 0);
      push_seq(1);
      pulse(1);
      ok = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (doneb) begin ok = 1; break; end
      end
      chk("b_done_timeout", ok, 1);
      chk("sb_empty_b", qb.size(), 0);
      chk("b_hold_data", db, entry(B_BASE, B_STEP, 3));
      chk("b_ovr", ovrb, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/init_write_seq.md
Name: init_write_seq

Overview:
- Upstream initial-value loader. After reset releases, it drives a fixed table of register initial values into a downstream register/check stage over a valid/ready write channel.
- Writes are strictly ordered.
- Reports completion with `done` and exposes a free-running cycle count. The downstream checker uses that count to sample loaded values at known cycles.

Parameters:
- NUM_REGS, 4: number of table entries written per sequence (1..2^ADDR_W).
- ADDR_W, 2: width of wr_addr.
- DATA_W, 32: width of wr_data.
- BASE_VAL, 22: value written to address 0.
- STEP_VAL, 11: increment between consecutive entries. Entry i = (BASE_VAL + i*STEP_VAL) mod 2^DATA_W.
- AUTO_START, 1: 1 = start the sequence automatically on the first clock after reset; 0 = wait for `start`.

Ports:
- clk       input   1        single clock, rising edge
- rst_n     input   1        asynchronous, active-low reset
- start     input   1        one-cycle request to (re)run the sequence
- wr_valid  output  1        write request valid
- wr_ready  input   1        downstream accepts write
- wr_addr   output  ADDR_W   write address = entry index
- wr_data   output  DATA_W   write data = table entry value
- busy      output  1        sequence in progress
- done      output  1        sequence complete, held until restart or reset
- start_ovr output  1        sticky: start seen while busy
- cyc       output  32       posedges since reset release

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs go to 0 immediately (wr_valid, wr_addr, wr_data, busy, done, start_ovr, cyc); FSM enters IDLE; index = 0.
  - Reset asserted mid-sequence aborts the sequence; the partial write is dropped.
  - Deassertion takes effect at the next posedge.
- cyc increments by 1 on every posedge with rst_n=1 and wraps at 2^32.
  - cyc is independent of FSM state.
- FSM states: IDLE, WRITE, DONE.
- IDLE -> WRITE on a posedge when AUTO_START=1 and this is the first posedge after reset, or when start=1.
  - On entry: wr_valid=1, wr_addr=0, wr_data=BASE_VAL, busy=1, done=0.
- WRITE, handshake:
  - A transfer occurs on a posedge where wr_valid=1 and wr_ready=1.
  - While wr_ready=0, wr_valid, wr_addr and wr_data stay stable.
  - wr_valid never drops without a transfer.
- WRITE, transfer at index < NUM_REGS-1: index+1. Next cycle presents the next entry with no bubble, so wr_valid stays 1.
- WRITE, transfer at index = NUM_REGS-1: go to DONE.
  - wr_valid=0, busy=0, done=1.
  - wr_addr/wr_data hold the last entry.
- DONE: done holds.
  - start=1 re-enters WRITE from index 0 (same as the IDLE transition) and clears done.
- Any state other than DONE: done=0.
- Throughput and latency:
  - One entry per cycle with wr_ready held high.
  - With AUTO_START=1 and wr_ready=1, done rises at the posedge where cyc becomes NUM_REGS+1.
- start while busy=1 is ignored and sets start_ovr. start_ovr is cleared only by reset.
- start in IDLE when AUTO_START=1 on the same first posedge as the auto-start: a single start, no overrun.
- Arithmetic:
  - The entry value uses DATA_W-bit wraparound addition.
  - wr_addr is index truncated to ADDR_W.
  - NUM_REGS > 2^ADDR_W is illegal; flag it with an elaboration-time $error.

Test Plan:
- Defaults, wr_ready=1, release rst_n before posedge 1 -> transfers (0,22),(1,33),(2,44),(3,55) at cyc 1..4; done=1 with cyc=5; wr_valid=0 thereafter.
- Defaults, wr_ready low on odd cycles -> wr_addr/wr_data stable while stalled; same four values in order; done asserts the cycle after the 4th transfer.
- Assert start at cyc=2 during a sequence -> start_ovr=1; sequence unaffected, still four writes; start_ovr stays 1 until reset.
- In DONE, pulse start -> done drops next cycle; writes restart at (0,22); done re-asserts after 4 more transfers.
- Drop rst_n asynchronously mid-cycle after the 2nd transfer -> all outputs 0 without a clock edge; after release the sequence restarts at (0,22) and cyc restarts from 1.
- AUTO_START=0, BASE_VAL=32'hFFFFFFF0, STEP_VAL=8 -> idle until start; writes FFFFFFF0, FFFFFFF8, 00000000, 00000008.
